fc_layer_ctrl: RTL
==================

FC_LAYER_CTRL -- requirements
Module: fc_layer_ctrl

Interface
REQ-001 SHALL have parameter IN_DATA_WIDTH, default 9: node/weight/bias element width.
REQ-002 SHALL have parameter NUM_IN, default 16, range 2..256: inputs per output neuron.
REQ-003 SHALL have parameter NUM_OUT, default 4, range 1..64: output neurons per layer.
REQ-004 SHALL have localparams ACC_WIDTH = 4*IN_DATA_WIDTH, NA = clog2(NUM_IN), WA = clog2(NUM_IN*NUM_OUT), OA = clog2(NUM_OUT), each minimum 1.
REQ-005 SHALL provide clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL provide reset_n, input, 1: synchronous, active-low reset.
REQ-007 SHALL provide i_start, input, 1: start-layer pulse; ignored unless in IDLE.
REQ-008 SHALL provide i_abort, input, 1: cancel the layer and return to IDLE.
REQ-009 SHALL provide o_node_addr, output, NA: node buffer read address; read latency 1 cycle.
REQ-010 SHALL provide o_wegt_addr, output, WA: weight buffer read address; read latency 1 cycle.
REQ-011 SHALL provide o_bias_addr, output, OA: bias buffer read address; read latency 1 cycle.
REQ-012 SHALL provide o_bias_en, output, 1: external mux passes bias data to the MAC core when 1 and zero when 0.
REQ-013 SHALL provide o_core_run, output, 1: clear strobe to the MAC core.
REQ-014 SHALL provide o_core_valid, output, 1: accumulate enable to the MAC core.
REQ-015 SHALL provide i_core_result, input, ACC_WIDTH: signed accumulator from the MAC core.
REQ-016 SHALL provide o_res_valid, output, 1; i_res_ready, input, 1; o_res_data, output, ACC_WIDTH; o_res_idx, output, OA: result stream with valid/ready handshake.
REQ-017 SHALL provide o_busy, output, 1, and o_done, output, 1: o_done is a one-cycle pulse when the layer completes.

Function
REQ-018 SHALL implement the FSM IDLE -> CLEAR -> FEED -> DRAIN -> OUT, then OUT -> CLEAR for the next neuron, or OUT -> IDLE after neuron NUM_OUT-1 with o_done=1 for one cycle.
REQ-019 IDLE: when i_start=1, SHALL go to CLEAR with neuron index n=0.
REQ-020 CLEAR: SHALL last exactly 1 cycle with o_core_run=1.
REQ-021 FEED: SHALL last exactly NUM_IN cycles; in cycle k, o_node_addr=k, o_wegt_addr=n*NUM_IN+k and o_bias_addr=n.
REQ-022 o_core_valid SHALL equal the FEED-state flag delayed by 1 cycle, aligning it with the returned memory data.
REQ-023 o_bias_en SHALL be 1 only in the cycle where o_core_valid=1 for k=NUM_IN-1, so the bias is added exactly once per neuron.
REQ-024 DRAIN: SHALL last 2 cycles (the last valid beat, then the accumulator update) and SHALL capture i_core_result into the output register on its final cycle.
REQ-025 OUT: SHALL hold o_res_valid=1 with o_res_data and o_res_idx=n stable until i_res_ready=1; the transfer occurs on the edge where both are 1.
REQ-026 If i_res_ready is already 1 on entry to OUT, the SHALL occupy OUT for one cycle; per-neuron latency from entering CLEAR to o_res_valid SHALL be NUM_IN+3 cycles.
REQ-027 o_res_data SHALL be passed through without truncation or saturation, as two's complement.
REQ-028 o_busy SHALL be 1 in every state except IDLE.
REQ-029 i_start outside IDLE SHALL be ignored; i_start in the same cycle as o_done SHALL be ignored.
REQ-030 i_abort in any non-IDLE state SHALL go to IDLE on the next edge: o_res_valid=0, o_core_valid=0, no o_done, and the pending result is discarded.
REQ-031 i_abort SHALL take priority over i_start and over i_res_ready.
REQ-032 o_core_run SHALL also pulse for 1 cycle on abort, so the core is cleared.

Reset
REQ-033 On a clock edge with reset_n=0, the block SHALL enter IDLE with n=0, k=0 and every output 0, including all address outputs and o_res_data.
REQ-034 Reset SHALL take priority over i_abort and i_start; reset asserted mid-FEED or mid-OUT SHALL cause no o_done and no result transfer.

Structure
REQ-035 Package fc_pkg SHALL hold the FSM state enum (IDLE, CLEAR, FEED, DRAIN, OUT) and the ACC_WIDTH derivation, shared with the MAC core.
REQ-036 Sub-module fc_addr_gen SHALL hold the k/n counters and address arithmetic; the MAC core is instantiated outside this block.

Verification
REQ-037 With NUM_IN=4, NUM_OUT=2, nodes {1,2,3,4}, weights all 1 and bias {5,-3}, after one i_start the bench SHALL see results 15 (idx 0) and 7 (idx 1), then o_done.
REQ-038 With weights all -1 and bias 5, the bench SHALL see result -5, as sign-extended 36-bit 0xFFFFFFFFB.
REQ-039 With i_res_ready held 0 for 10 cycles in OUT, o_res_valid and o_res_data SHALL stay stable and no new CLEAR SHALL occur.
REQ-040 With i_abort at FEED k=2, the next cycle SHALL show IDLE, o_busy=0 and a single o_core_run pulse; a restart SHALL then yield the correct 15.
REQ-041 With reset_n=0 during OUT, all outputs SHALL be 0 on the next edge, and i_start=1 during FEED SHALL be ignored with an unchanged result sequence.
REQ-042 With o_core_valid counted per neuron, the bench SHALL see exactly NUM_IN beats, exactly one o_bias_en, and o_wegt_addr sequence 4..7 for n=1.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer controller and its MAC core.
// Holds the controller state encoding and the accumulator/address width helpers,
// so the controller and the MAC core agree on ACC_WIDTH.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } fc_state_e;

    // Accumulator width: wide enough for long dot products without overflow.
    function automatic int acc_width(input int in_w);
        return in_w * 32'sd4;
    endfunction

    // Address width for a table of v entries; never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 32'sd1) ? 32'sd1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fc_addr_gen.sv
// Input-index (k), neuron-index (n) counters and buffer read addresses.
// Ports:
//   clk, reset_n     : clock, synchronous active-low reset
//   clear            : restart at neuron 0, weight 0 (layer start, abort, done)
//   feed             : current cycle is a FEED cycle; advance k and weight address
//   next_neuron      : result accepted and more neurons remain; advance n
//   k, n, wegt_addr  : registered indices / weight address
//   k_last, n_last   : k == NUM_IN-1, n == NUM_OUT-1
module fc_addr_gen
    import fc_pkg::*;
#(
    parameter int NUM_IN  = 16,
    parameter int NUM_OUT = 4,
    parameter int NA      = 4,
    parameter int WA      = 6,
    parameter int OA      = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          feed,
    input  logic          next_neuron,
    output logic [NA-1:0] k,
    output logic [OA-1:0] n,
    output logic [WA-1:0] wegt_addr,
    output logic          k_last,
    output logic          n_last
);

    logic [NA-1:0] k_r;
    logic [OA-1:0] n_r;
    logic [WA-1:0] wegt_r;

    assign k_last    = (k_r == NA'(NUM_IN - 1));
    assign n_last    = (n_r == OA'(NUM_OUT - 1));
    assign k         = k_r;
    assign n         = n_r;
    assign wegt_addr = wegt_r;

    // Input index: walks 0..NUM_IN-1 during FEED and rests at 0 otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            k_r <= '0;
        end else if (clear) begin
            k_r <= '0;
        end else if (feed && !k_last) begin
            k_r <= k_r + NA'(1);
        end else begin
            k_r <= '0;
        end
    end

    // Weight address only moves in FEED, so neuron n starts at n*NUM_IN
    // without needing a multiplier.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wegt_r <= '0;
        end else if (clear) begin
            wegt_r <= '0;
        end else if (feed) begin
            wegt_r <= wegt_r + WA'(1);
        end else begin
            wegt_r <= wegt_r;
        end
    end

    // Neuron index: advances after each accepted result except the last.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            n_r <= '0;
        end else if (clear) begin
            n_r <= '0;
        end else if (next_neuron) begin
            n_r <= n_r + OA'(1);
        end else begin
            n_r <= n_r;
        end
    end

endmodule

// File: rtl/fc_layer_ctrl.sv
// Sequencer for one fully-connected layer driving an external MAC core.
// Per neuron: CLEAR (core cleared) -> FEED (NUM_IN buffer reads) -> DRAIN (two
// cycles for the last beat and accumulator update) -> OUT (valid/ready result).
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   i_start, i_abort             : start a layer (IDLE only) / cancel it
//   o_node_addr/o_wegt_addr/o_bias_addr : buffer read addresses (1-cycle latency)
//   o_bias_en                    : bias mux select, high on the final beat only
//   o_core_run, o_core_valid     : MAC clear strobe / accumulate enable
//   i_core_result                : MAC accumulator
//   o_res_valid, i_res_ready, o_res_data, o_res_idx : result stream
//   o_busy, o_done               : not-IDLE flag / one-cycle layer-complete pulse
module fc_layer_ctrl
    import fc_pkg::*;
#(
    parameter int  IN_DATA_WIDTH = 9,
    parameter int  NUM_IN        = 16,
    parameter int  NUM_OUT       = 4,
    localparam int ACC_WIDTH     = acc_width(IN_DATA_WIDTH),
    localparam int NA            = clog2_min1(NUM_IN),
    localparam int WA            = clog2_min1(NUM_IN * NUM_OUT),
    localparam int OA            = clog2_min1(NUM_OUT)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    output logic [NA-1:0]        o_node_addr,
    output logic [WA-1:0]        o_wegt_addr,
    output logic [OA-1:0]        o_bias_addr,
    output logic                 o_bias_en,
    output logic                 o_core_run,
    output logic                 o_core_valid,
    input  logic [ACC_WIDTH-1:0] i_core_result,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic [ACC_WIDTH-1:0] o_res_data,
    output logic [OA-1:0]        o_res_idx,
    output logic                 o_busy,
    output logic                 o_done
);

    fc_state_e state_r, next_state_s;
    logic      drain_r;
    logic      abort_hit_s, start_ok_s, xfer_s;
    logic      k_last_s, n_last_s;
    logic [OA-1:0] n_s;

    logic core_run_s, core_valid_s, bias_en_s, res_valid_s, busy_s, done_s, capture_s;
    logic core_run_r, core_valid_r, bias_en_r, res_valid_r, busy_r, done_r;
    logic [ACC_WIDTH-1:0] res_data_r;

    assign abort_hit_s = i_abort && (state_r != IDLE);
    // A start arriving together with the done pulse belongs to the old layer.
    assign start_ok_s  = i_start && !done_r;
    assign xfer_s      = (state_r == OUT) && i_res_ready && !abort_hit_s;

    fc_addr_gen #(
        .NUM_IN  (NUM_IN),
        .NUM_OUT (NUM_OUT),
        .NA      (NA),
        .WA      (WA),
        .OA      (OA)
    ) u_addr_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (abort_hit_s || ((state_r == IDLE) && start_ok_s) || done_s),
        .feed        (state_r == FEED),
        .next_neuron (xfer_s && !n_last_s),
        .k           (o_node_addr),
        .n           (n_s),
        .wegt_addr   (o_wegt_addr),
        .k_last      (k_last_s),
        .n_last      (n_last_s)
    );

    assign o_bias_addr = n_s;
    assign o_res_idx   = n_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        next_state_s = state_r;
        if (abort_hit_s) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    if (start_ok_s) next_state_s = CLEAR; else next_state_s = IDLE;
                CLEAR:   next_state_s = FEED;
                FEED:    if (k_last_s) next_state_s = DRAIN; else next_state_s = FEED;
                DRAIN:   if (drain_r) next_state_s = OUT; else next_state_s = DRAIN;
                OUT: begin
                    if (!i_res_ready) begin
                        next_state_s = OUT;
                    end else if (n_last_s) begin
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = CLEAR;
                    end
                end
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Output decode: values the output registers take on the next edge.
    // core_valid is FEED delayed by one cycle to line up with buffer read data.
    always_comb begin
        core_run_s   = (next_state_s == CLEAR) || abort_hit_s;
        core_valid_s = (state_r == FEED) && !abort_hit_s;
        bias_en_s    = (state_r == FEED) && k_last_s && !abort_hit_s;
        res_valid_s  = (next_state_s == OUT);
        busy_s       = (next_state_s != IDLE);
        done_s       = xfer_s && n_last_s;
        capture_s    = (state_r == DRAIN) && drain_r && !abort_hit_s;
    end

    // Marks the second DRAIN cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drain_r <= 1'b0;
        end else begin
            drain_r <= (state_r == DRAIN) && (next_state_s == DRAIN);
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            core_run_r   <= 1'b0;
            core_valid_r <= 1'b0;
            bias_en_r    <= 1'b0;
            res_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            core_run_r   <= core_run_s;
            core_valid_r <= core_valid_s;
            bias_en_r    <= bias_en_s;
            res_valid_r  <= res_valid_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    // Result register: captured after the accumulator settles, cleared on abort.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            res_data_r <= '0;
        end else if (abort_hit_s) begin
            res_data_r <= '0;
        end else if (capture_s) begin
            res_data_r <= i_core_result;
        end else begin
            res_data_r <= res_data_r;
        end
    end

    assign o_core_run   = core_run_r;
    assign o_core_valid = core_valid_r;
    assign o_bias_en    = bias_en_r;
    assign o_res_valid  = res_valid_r;
    assign o_res_data   = res_data_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;

endmodule
